seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Multiplexed 8-digit seven-segment display driver; consumes the 32-bit debug value exported by the pipeline top (e.g. debug_write_data / debug_program_counter).
- Drives the board's shared cathode bus (out7) and digit anodes (en_out).
- Sits directly downstream of the datapath top, between the debug value and the board pins.
- Values are frame-synchronous: a new value never tears mid-scan.

Parameters:
- REFRESH_DIV, 100000, Clk cycles each digit is lit; legal range ≥ 2.
- NUM_DIGITS, 8, digits scanned; fixed at 8 for this board, kept for bench scaling.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Data_in  in  32  value to display; nibble i drives digit i
- Load  in  1  one-cycle strobe; capture Data_in as pending value
- Pending  out  1  high while a captured value awaits the next frame boundary
- out7  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
- en_out  out  8  digit enables, active-low one-hot, registered

Behaviour:
- Reset (async, any time, including mid-frame):
  - tick counter = 0, digit index = 0, display register = 0, pending register = 0.
  - Pending = 0, out7 = 7'h7F (all off), en_out = 8'hFF (all off).
- Tick counter:
  - Counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances mod NUM_DIGITS.
- Frame boundary: the cycle in which the index wraps 7→0.
- Output registers load every cycle from the current index:
  - en_out = ~(1 << index).
  - out7 = decode(display[4*index+3 : 4*index]).
  - Latency from index change to pins: 1 cycle.
  - First enabled digit after reset release: digit 0, on the first cycle after Reset falls.
- Load handling:
  - Load with no frame boundary that cycle → pending register ← Data_in, Pending ← 1.
  - Load while Pending = 1 → pending register overwritten (newest wins), Pending stays 1.
  - Frame boundary with Pending = 1 and no Load → display ← pending register, Pending ← 0.
  - Load coincident with a frame boundary → display ← Data_in directly (bypass), Pending ← 0; any older pending value is discarded.
  - Frame boundary with Pending = 0 → display unchanged.
- Decode table (active-low, {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Exactly one en_out bit is low at all times after reset.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: a digit is blanked (out7 = 7'h7F; en_out still scans normally) when its nibble and every higher nibble of the display register are zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all 8 digits are always shown, including leading zeros.

Decomposition:
- Shared package seven_seg_pkg:
  - 16-entry segment pattern constant array.
  - SEG_BLANK = 7'h7F constant.
  - NUM_DIGITS default.
- One sub-module: hex_to_7seg, a combinational nibble→segment decoder instantiated once and fed by the index mux.

Test Plan (REFRESH_DIV=4):
- Reset held 3 cycles, then released:
  - During reset: out7=7F, en_out=FF, Pending=0.
  - First cycle after release: en_out=FE, out7=40.
- Load Data_in=32'h89ABCDEF, then run one full frame + 1 (33 cycles):
  - After the boundary, digit 0 shows 0E and digit 7 shows 00.
  - en_out walks FE→FD→…→7F, each held 4 cycles.
- Load 32'h11111111 at digit 3 mid-frame:
  - Pending=1; digits 3..7 of the current frame still show the old value.
  - Switch to 79 at the next boundary; Pending=0.
- Two Loads (32'h22222222 then 32'h33333333) within one frame:
  - Next frame shows 30 on every digit; 24 never appears.
- Load 32'h00000005 exactly on the boundary cycle:
  - Digit 0 of the immediately following frame shows 12; Pending stays 0.
- Assert Reset mid-digit-5, then release:
  - Outputs go 7F/FF asynchronously (same cycle).
  - Scan restarts at digit 0 with display 0 (out7=40).
  - With SEVEN_SEG_LEADING_ZERO_BLANK_EN and Data 32'h00000A00: digits 3..7 = 7F, digit 2 = 08, digits 1 and 0 = 40.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants for the seven-segment scanner: the active-low segment
// patterns for hex digits 0..F ({g,f,e,d,c,b,a}), the all-off pattern, and
// the default digit count of the board.
// No ports (package).
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int NUM_DIGITS_DEFAULT = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index = nibble value; bit 0 = segment a, bit 6 = segment g, 0 = lit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational nibble to active-low segment decoder.
// Ports:
//   nibble  in  4  hex digit value
//   seg     out 7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Multiplexed seven-segment display driver. Scans NUM_DIGITS digits, each lit
// for REFRESH_DIV clock cycles. A loaded value is held as pending and only
// moved into the display register at a frame boundary (index wrapping from
// the last digit to 0), so a frame never shows a mix of two values.
//
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN
//   When defined, a digit whose nibble and all higher nibbles are zero is
//   blanked (digit 0 is never blanked). When undefined, every digit is shown.
//
// Ports:
//   Clk      in   1              system clock
//   Reset    in   1              asynchronous, active-high reset
//   Data_in  in   4*NUM_DIGITS   value to display; nibble i drives digit i
//   Load     in   1              one-cycle strobe, captures Data_in
//   Pending  out  1              a captured value awaits the next frame
//   out7     out  7              segments {g,f,e,d,c,b,a}, active-low, registered
//   en_out   out  NUM_DIGITS     digit enables, active-low one-hot, registered
// -----------------------------------------------------------------------------
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = NUM_DIGITS_DEFAULT
)
(
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] Data_in,
    input  logic                    Load,
    output logic                    Pending,
    output logic [6:0]              out7,
    output logic [NUM_DIGITS-1:0]   en_out
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    logic [TICK_W-1:0]       tick;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] pend_value;

    logic                    tick_done;
    logic                    frame_boundary;
    logic [3:0]              nibble;
    logic [6:0]              seg_dec;
    logic                    blank;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   en_nxt;

    assign tick_done      = (tick == TICK_W'(REFRESH_DIV - 1));
    assign frame_boundary = tick_done && (idx == IDX_W'(NUM_DIGITS - 1));

    // Refresh timing: tick counter and digit index.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick_done) begin
            tick <= '0;
            idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Frame-synchronous value update. A Load on the boundary cycle bypasses
    // the pending register and wins over any older pending value.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            display    <= '0;
            pend_value <= '0;
            Pending    <= 1'b0;
        end else if (frame_boundary) begin
            if (Load) begin
                display <= Data_in;
            end else if (Pending) begin
                display <= pend_value;
            end
            Pending <= 1'b0;
        end else if (Load) begin
            pend_value <= Data_in;
            Pending    <= 1'b1;
        end
    end

    assign nibble = display[4*idx +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .seg    (seg_dec)
    );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Shifting the current digit down to bit 0 leaves exactly this nibble and
    // the higher ones; all zero means the digit is a leading zero.
    assign blank = (idx != '0) && ((display >> {idx, 2'b00}) == '0);
`else
    assign blank = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        seg_nxt = seg_dec;
        if (blank) begin
            seg_nxt = SEG_BLANK;
        end
        en_nxt = ~(NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out7   <= SEG_BLANK;
            en_out <= '1;
        end else begin
            out7   <= seg_nxt;
            en_out <= en_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
// Self-checking bench for seven_seg_scanner with REFRESH_DIV = 4. A reference
// model derives the lit digit from the number of clock edges since reset and
// applies the load/pending rules to whole 32-bit values.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Data_in;
    logic        Load;
    logic        Pending;
    logic [6:0]  out7;
    logic [7:0]  en_out;

    int total = 0;
    int bad   = 0;

    seven_seg_scanner #(.REFRESH_DIV(DIV), .NUM_DIGITS(8)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Data_in (Data_in),
        .Load    (Load),
        .Pending (Pending),
        .out7    (out7),
        .en_out  (en_out)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input logic [31:0] v, input int d);
        logic [3:0] n;
        n = v[4*d +: 4];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (d != 0 && (v >> (4*d)) == 32'h0) return 7'h7F;
`endif
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    int unsigned m_cyc;      // clock edges seen since reset released
    logic [31:0] m_disp, m_pend;
    logic        m_pflag;
    logic [6:0]  m_out7;
    logic [7:0]  m_en;
    int          m_d;
    bit          m_bound;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_cyc   <= 0;
            m_disp  <= 32'h0;
            m_pend  <= 32'h0;
            m_pflag <= 1'b0;
            m_out7  <= 7'h7F;
            m_en    <= 8'hFF;
        end else begin
            m_d     = (m_cyc / DIV) % 8;
            m_bound = (m_cyc % FRAME) == FRAME - 1;
            m_en   <= ~(8'd1 << m_d);
            m_out7 <= seg_of(m_disp, m_d);
            if (m_bound) begin
                if (Load) m_disp <= Data_in;
                else if (m_pflag) m_disp <= m_pend;
                m_pflag <= 1'b0;
            end else if (Load) begin
                m_pend  <= Data_in;
                m_pflag <= 1'b1;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    // Waits (bounded) until the model's edge count sits at phase p of a frame.
    task automatic wait_phase(input int p);
        for (int k = 0; k < 2 * FRAME && (m_cyc % FRAME) != p; k++) @(negedge Clk);
        total++;
        if ((m_cyc % FRAME) != p) begin
            bad++;
            $display("FAIL wait_phase: phase=%0d required=%0d", m_cyc % FRAME, p);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        Reset = 1'b1; Load = 1'b0; Data_in = 32'h0;
        repeat (3) begin
            @(negedge Clk);
            total++;
            if (out7 !== 7'h7F || en_out !== 8'hFF || Pending !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: out7=%h en=%h pend=%b required 7f ff 0", out7, en_out, Pending);
            end
        end
        Reset = 1'b0;
        @(negedge Clk);
        total++;
        if (out7 !== 7'h40 || en_out !== 8'hFE || Pending !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: out7=%h en=%h pend=%b required 40 fe 0", out7, en_out, Pending);
        end
    endtask

    task automatic test_frame_walk;
        Data_in = 32'h89ABCDEF; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        for (int i = 0; i < FRAME + 12; i++) begin
            @(negedge Clk);
            total++;
            if (out7 !== m_out7 || en_out !== m_en || Pending !== m_pflag) begin
                bad++;
                $display("FAIL walk: out7=%h en=%h pend=%b required %h %h %b", out7, en_out, Pending, m_out7, m_en, m_pflag);
            end
        end
        wait_phase(2);
        total++;
        if (out7 !== 7'h0E || en_out !== 8'hFE) begin
            bad++;
            $display("FAIL walk_digit0: out7=%h en=%h required 0e fe", out7, en_out);
        end
        wait_phase(30);
        total++;
        if (out7 !== 7'h00 || en_out !== 8'h7F) begin
            bad++;
            $display("FAIL walk_digit7: out7=%h en=%h required 00 7f", out7, en_out);
        end
    endtask

    task automatic test_mid_frame_load;
        wait_phase(13);
        Data_in = 32'h11111111; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        total++;
        if (Pending !== 1'b1) begin
            bad++;
            $display("FAIL mid_pending: pend=%b required 1", Pending);
        end
        while ((m_cyc % FRAME) != 1) begin
            total++;
            if (out7 === 7'h79 || out7 !== m_out7 || en_out !== m_en) begin
                bad++;
                $display("FAIL mid_old_value: out7=%h en=%h required %h %h", out7, en_out, m_out7, m_en);
            end
            @(negedge Clk);
        end
        total++;
        if (out7 !== 7'h79 || Pending !== 1'b0) begin
            bad++;
            $display("FAIL mid_switch: out7=%h pend=%b required 79 0", out7, Pending);
        end
    endtask

    task automatic test_back_to_back;
        wait_phase(5);
        Data_in = 32'h22222222; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        wait_phase(9);
        Data_in = 32'h33333333; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        wait_phase(1);
        for (int i = 0; i < FRAME; i++) begin
            total++;
            if (out7 !== 7'h30 || out7 !== m_out7 || en_out !== m_en || Pending !== 1'b0) begin
                bad++;
                $display("FAIL back_to_back: out7=%h en=%h pend=%b required 30 %h 0", out7, en_out, Pending, m_en);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_boundary_load;
        wait_phase(20);
        Data_in = 32'h77777777; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        wait_phase(31);
        Data_in = 32'h00000005; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        total++;
        if (Pending !== 1'b0) begin
            bad++;
            $display("FAIL boundary_pending: pend=%b required 0", Pending);
        end
        @(negedge Clk);
        total++;
        if (out7 !== 7'h12 || en_out !== 8'hFE || Pending !== 1'b0) begin
            bad++;
            $display("FAIL boundary_bypass: out7=%h en=%h pend=%b required 12 fe 0", out7, en_out, Pending);
        end
    endtask

    task automatic test_async_reset;
        int d;
        logic [6:0] hi;
        wait_phase(22);
        #2 Reset = 1'b1;
        #1;
        total++;
        if (out7 !== 7'h7F || en_out !== 8'hFF || Pending !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: out7=%h en=%h pend=%b required 7f ff 0", out7, en_out, Pending);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        total++;
        if (out7 !== 7'h40 || en_out !== 8'hFE) begin
            bad++;
            $display("FAIL restart: out7=%h en=%h required 40 fe", out7, en_out);
        end
        Data_in = 32'h00000A00; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        hi = 7'h7F;
`else
        hi = 7'h40;
`endif
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge Clk);
            if (m_cyc > FRAME) begin
                d = ((m_cyc - 1) % FRAME) / DIV;
                total++;
                if (out7 !== (d == 2 ? 7'h08 : (d < 2 ? 7'h40 : hi)) || out7 !== m_out7) begin
                    bad++;
                    $display("FAIL blank_digit%0d: out7=%h required %h", d, out7, m_out7);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 800; i++) begin
            Load = ($urandom_range(0, 5) == 0);
            Data_in = $urandom;
            if ($urandom_range(0, 3) == 0) Data_in = Data_in & 32'h0000_0FFF;
            @(negedge Clk);
            total++;
            if (out7 !== m_out7 || en_out !== m_en || Pending !== m_pflag) begin
                bad++;
                $display("FAIL random: out7=%h en=%h pend=%b required %h %h %b", out7, en_out, Pending, m_out7, m_en, m_pflag);
            end
        end
        Load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_walk();
        test_mid_frame_load();
        test_back_to_back();
        test_boundary_load();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
